// File: rtl/soc_sram_responder.sv
// soc_sram_responder: inst/data SRAM responder with config regs; timer/IRQ built only with SRAM_RESP_TIMER_EN
module soc_sram_responder #(
  parameter int RAM_AW = 10,
  parameter logic [15:0] CONF_HI = 16'hBFAF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_en,
  input  logic [31:0]       inst_sram_addr,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  input  logic              ld_en,
  input  logic              ld_sel,
  input  logic [RAM_AW-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic [7:0]        switch_in,
  output logic [15:0]       led,
  output logic [31:0]       num_data,
  output logic              timer_irq
);
  localparam int N = 1 << RAM_AW;
  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = be[i] ? wd[8*i+:8] : old[8*i+:8];
    return m;
  endfunction
  logic [31:0] iram [N];
  logic [31:0] dram [N];
  logic [RAM_AW-1:0] i_idx, d_idx;
  logic [15:0] off;
  logic is_conf, cw;
  logic [31:0] ram_q, conf_q, conf_rd, timer_rd, led_w;
  logic sel_q;
  logic [7:0] sw_s1, sw_s2;
  logic unused_ok;
  assign i_idx = inst_sram_addr[RAM_AW+1:2];
  assign d_idx = data_sram_addr[RAM_AW+1:2];
  assign off = data_sram_addr[15:0];
  assign is_conf = data_sram_addr[31:16] == CONF_HI;
  assign cw = data_sram_en & is_conf;
  assign led_w = merge_be({16'h0, led}, data_sram_wdata, data_sram_wen);
  assign unused_ok = ^{inst_sram_addr[31:RAM_AW+2], inst_sram_addr[1:0], led_w[31:16]};
  always_ff @(posedge clk) begin
    if (ld_en && !ld_sel) iram[ld_addr] <= ld_wdata;
  end
  always_ff @(posedge clk) begin
    if (!resetn) inst_sram_rdata <= '0;
    else if (inst_sram_en) inst_sram_rdata <= iram[i_idx];
  end
  // loader is written last so it overrides a same-word CPU store
  always_ff @(posedge clk) begin
    if (data_sram_en && !is_conf)
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i]) dram[d_idx][8*i+:8] <= data_sram_wdata[8*i+:8];
    if (ld_en && ld_sel) dram[ld_addr] <= ld_wdata;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ram_q <= '0;
      conf_q <= '0;
      sel_q <= 1'b0;
    end else if (data_sram_en) begin
      ram_q <= dram[d_idx];
      conf_q <= conf_rd;
      sel_q <= is_conf;
    end
  end
  assign data_sram_rdata = sel_q ? conf_q : ram_q;
  always_comb begin
    conf_rd = off == 16'h0000 ? {16'h0, led} :
              off == 16'h0004 ? {24'h0, sw_s2} :
              off == 16'h0008 ? num_data : timer_rd;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led <= '0;
      num_data <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switch_in;
      sw_s2 <= sw_s1;
      if (cw && off == 16'h0000) led <= led_w[15:0];
      if (cw && off == 16'h0008) num_data <= merge_be(num_data, data_sram_wdata, data_sram_wen);
    end
  end
`ifdef SRAM_RESP_TIMER_EN
  logic [31:0] timer, timer_cmp;
  logic irq, irq_clr;
  assign irq_clr = cw && off == 16'h0014 && data_sram_wen[0] && data_sram_wdata[0];
  always_comb begin
    timer_rd = off == 16'h000C ? timer :
               off == 16'h0010 ? timer_cmp :
               off == 16'h0014 ? {31'h0, irq} : 32'h0;
  end
  // a CPU write to TIMER replaces the increment; a match beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer <= '0;
      timer_cmp <= '1;
      irq <= 1'b0;
    end else begin
      timer <= (cw && off == 16'h000C) ? merge_be(timer, data_sram_wdata, data_sram_wen) : timer + 32'd1;
      if (cw && off == 16'h0010) timer_cmp <= merge_be(timer_cmp, data_sram_wdata, data_sram_wen);
      irq <= (timer == timer_cmp) | (irq & ~irq_clr);
    end
  end
  assign timer_irq = irq;
`else
  assign timer_rd = '0;
  assign timer_irq = 1'b0;
`endif
endmodule
